// File: rtl/oric_tape_pkg.sv
// Shared types and constants for the Oric cassette-input decoder.
// Contents: framing FSM state enum, sync-marker constants, default timing values
// (nominal 1-bit / 0-bit cycle lengths at 16 MHz and the thresholds derived from them).
package oric_tape_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   // Sync leader byte, block marker, and how many leader bytes must precede the marker.
   localparam logic [7:0] SYNC_BYTE  = 8'h16;
   localparam logic [7:0] SYNC_MARK  = 8'h24;
   localparam logic [1:0] SYNC_COUNT = 2'd3;

   // Nominal cycle lengths in 16 MHz clocks for a 1 bit (short) and a 0 bit (long).
   localparam int NOM_ONE_CYC    = 3328;
   localparam int NOM_ZERO_CYC   = 6656;
   localparam int DEF_PER_W      = 16;
   localparam int DEF_MIN_PERIOD = 1000;
   localparam int DEF_THRESH     = (NOM_ONE_CYC + NOM_ZERO_CYC) / 2;
   localparam int DEF_TIMEOUT    = 2 * NOM_ZERO_CYC;

endpackage

// File: rtl/tape_period_meter.sv
// Measures the period between rising edges of the tape input and classifies it as a bit.
// Ports: clk/reset, motor (low = idle), tape_in (async) in; bit_evt/bit_val/timeout_evt out.
// bit_evt and timeout_evt are registered one-cycle pulses, 3 clk after the pin edge.
module tape_period_meter #(
   parameter int PER_W      = 16,
   parameter int MIN_PERIOD = 1000,
   parameter int THRESH     = 4992,
   parameter int TIMEOUT    = 13312
) (
   input  logic clk,
   input  logic reset,
   input  logic motor,
   input  logic tape_in,
   output logic bit_evt,
   output logic bit_val,
   output logic timeout_evt
);

   localparam logic [PER_W:0] MIN_P = (PER_W + 1)'(MIN_PERIOD);
   localparam logic [PER_W:0] THR_P = (PER_W + 1)'(THRESH);
   localparam logic [PER_W:0] TMO_P = (PER_W + 1)'(TIMEOUT);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             prev_q, prev_d;
   logic             armed_q, armed_d;
   logic [PER_W-1:0] cnt_q, cnt_d;
   logic             bit_evt_q, bit_evt_d;
   logic             bit_val_q, bit_val_d;
   logic             tmo_q, tmo_d;
   logic             rise;
   logic [PER_W:0]   per;

   assign rise = sync2_q & ~prev_q;
   // The counter is cleared on the accepting edge, so on the next edge it holds P-1.
   assign per  = {1'b0, cnt_q} + {{PER_W{1'b0}}, 1'b1};

   always_comb begin
      sync1_d   = tape_in;
      sync2_d   = sync1_q;
      prev_d    = sync2_q;
      cnt_d     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      armed_d   = armed_q;
      bit_evt_d = 1'b0;
      bit_val_d = 1'b0;
      tmo_d     = 1'b0;
      if (!motor) begin
         cnt_d   = '0;
         armed_d = 1'b0;
      end else if (rise && !armed_q) begin
         cnt_d   = '0;
         armed_d = 1'b1;
      end else if (rise && armed_q && per >= MIN_P && per < TMO_P) begin
         bit_evt_d = 1'b1;
         bit_val_d = (per < THR_P);
         cnt_d     = '0;
      end else if (armed_q && per == TMO_P) begin
         // Glitch edges (per < MIN_P) fall through to here and leave the count running.
         tmo_d   = 1'b1;
         armed_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         prev_q    <= 1'b0;
         armed_q   <= 1'b0;
         cnt_q     <= '0;
         bit_evt_q <= 1'b0;
         bit_val_q <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         prev_q    <= prev_d;
         armed_q   <= armed_d;
         cnt_q     <= cnt_d;
         bit_evt_q <= bit_evt_d;
         bit_val_q <= bit_val_d;
         tmo_q     <= tmo_d;
      end
   end

   assign bit_evt     = bit_evt_q;
   assign bit_val     = bit_val_q;
   assign timeout_evt = tmo_q;

endmodule

// File: rtl/oric_tape_decoder.sv
// Recovers start/8 data LSB-first/odd parity/stop framed bytes from the Oric tape input.
// Ports: clk, reset (sync, active-high), motor, tape_in in; byte_data, byte_valid, parity_err,
// frame_err, synced out. Optional ORIC_TAPE_SYNC_EN gates delivery on a 3x16h + 24h leader.
module oric_tape_decoder
   import oric_tape_pkg::*;
#(
   parameter int PER_W      = DEF_PER_W,
   parameter int MIN_PERIOD = DEF_MIN_PERIOD,
   parameter int THRESH     = DEF_THRESH,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       motor,
   input  logic       tape_in,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       synced
);

   logic       bit_evt, bit_val, timeout_evt;
   state_t     state_q, state_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic [7:0] shift_q, shift_d;
   logic       par_q, par_d;
   logic [7:0] byte_data_q, byte_data_d;
   logic       byte_valid_q, byte_valid_d;
   logic       parity_err_q, parity_err_d;
   logic       frame_err_q, frame_err_d;
   logic       deliver;
   logic       par_bad;

   tape_period_meter #(
      .PER_W      (PER_W),
      .MIN_PERIOD (MIN_PERIOD),
      .THRESH     (THRESH),
      .TIMEOUT    (TIMEOUT)
   ) u_meter (
      .clk         (clk),
      .reset       (reset),
      .motor       (motor),
      .tape_in     (tape_in),
      .bit_evt     (bit_evt),
      .bit_val     (bit_val),
      .timeout_evt (timeout_evt)
   );

   // Odd parity: data plus parity bit must contain an odd number of ones.
   assign par_bad = (par_q != ~^shift_q);

`ifdef ORIC_TAPE_SYNC_EN
   logic [1:0] sync_cnt_q, sync_cnt_d;
   logic       synced_q, synced_d;
`endif

   always_comb begin
      state_d      = state_q;
      bitcnt_d     = bitcnt_q;
      shift_d      = shift_q;
      par_d        = par_q;
      byte_data_d  = byte_data_q;
      byte_valid_d = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      deliver      = 1'b0;
`ifdef ORIC_TAPE_SYNC_EN
      sync_cnt_d   = sync_cnt_q;
      synced_d     = synced_q;
`endif
      if (!motor) begin
         // Relay off abandons any frame silently.
         state_d     = HUNT;
         bitcnt_d    = '0;
         shift_d     = '0;
         par_d       = 1'b0;
         byte_data_d = '0;
`ifdef ORIC_TAPE_SYNC_EN
         sync_cnt_d  = '0;
         synced_d    = 1'b0;
`endif
      end else begin
         case (state_q)
            HUNT: begin
               // 1 bits here are leader or stop filler.
               if (bit_evt && !bit_val) begin
                  state_d  = DATA;
                  bitcnt_d = '0;
               end
            end
            DATA: begin
               if (bit_evt) begin
                  shift_d  = {bit_val, shift_q[7:1]};
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) state_d = PARITY;
               end else if (timeout_evt) begin
                  frame_err_d = 1'b1;
                  state_d     = HUNT;
               end
            end
            PARITY: begin
               if (bit_evt) begin
                  par_d   = bit_val;
                  state_d = STOP;
               end else if (timeout_evt) begin
                  frame_err_d = 1'b1;
                  state_d     = HUNT;
               end
            end
            STOP: begin
               // A 0 stop bit aborts the frame and is not reused as the next start bit.
               if (bit_evt) begin
                  state_d = HUNT;
                  if (bit_val) deliver = 1'b1;
                  else         frame_err_d = 1'b1;
               end else if (timeout_evt) begin
                  frame_err_d = 1'b1;
                  state_d     = HUNT;
               end
            end
            default: state_d = HUNT;
         endcase

`ifdef ORIC_TAPE_SYNC_EN
         if (deliver) begin
            if (synced_q) begin
               byte_data_d  = shift_q;
               byte_valid_d = 1'b1;
               parity_err_d = par_bad;
            end else if (!par_bad && shift_q == SYNC_BYTE) begin
               if (sync_cnt_q != SYNC_COUNT) sync_cnt_d = sync_cnt_q + 2'd1;
            end else if (!par_bad && shift_q == SYNC_MARK && sync_cnt_q == SYNC_COUNT) begin
               synced_d   = 1'b1;
               sync_cnt_d = '0;
            end else begin
               sync_cnt_d = '0;
            end
         end
         if (frame_err_d || timeout_evt) begin
            sync_cnt_d = '0;
            synced_d   = 1'b0;
         end
`else
         if (deliver) begin
            byte_data_d  = shift_q;
            byte_valid_d = 1'b1;
            parity_err_d = par_bad;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= HUNT;
         bitcnt_q     <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         byte_data_q  <= '0;
         byte_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bitcnt_q     <= bitcnt_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         byte_data_q  <= byte_data_d;
         byte_valid_q <= byte_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

`ifdef ORIC_TAPE_SYNC_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_cnt_q <= '0;
         synced_q   <= 1'b0;
      end else begin
         sync_cnt_q <= sync_cnt_d;
         synced_q   <= synced_d;
      end
   end
   assign synced = synced_q;
`else
   assign synced = 1'b0;
`endif

   assign byte_data  = byte_data_q;
   assign byte_valid = byte_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_oric_tape_decoder.sv
// Self-checking bench for oric_tape_decoder with timing scaled down by ~100x.
module tb_oric_tape_decoder;

   localparam int MINP = 10;
   localparam int THR  = 50;
   localparam int TMO  = 134;
   localparam int T1   = 33;
   localparam int T0   = 67;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       motor = 1'b1;
   logic       tape_in = 1'b0;
   logic [7:0] byte_data;
   logic       byte_valid, parity_err, frame_err, synced;

   oric_tape_decoder #(
      .PER_W(16), .MIN_PERIOD(MINP), .THRESH(THR), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset(reset), .motor(motor), .tape_in(tape_in),
      .byte_data(byte_data), .byte_valid(byte_valid), .parity_err(parity_err),
      .frame_err(frame_err), .synced(synced)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         c;
      logic [7:0] d;
      logic       pe;
   } ev_t;
   ev_t bq[$];
   int  fq[$];
   int  stray_pe = 0;

   always @(negedge clk) begin
      ev_t e;
      if (byte_valid === 1'b1) begin
         e.c = cyc; e.d = byte_data; e.pe = parity_err;
         bq.push_back(e);
      end
      if (frame_err === 1'b1) fq.push_back(cyc);
      if (parity_err === 1'b1 && byte_valid !== 1'b1) stray_pe++;
   end

   int n_cmp = 0;
   int n_bad = 0;
   int last_rise = 0;
   logic [7:0] exp_last = 8'h00;
`ifdef ORIC_TAPE_SYNC_EN
   localparam bit SYNC_EN = 1'b1;
`else
   localparam bit SYNC_EN = 1'b0;
`endif
   bit m_synced = 1'b0;
   int m_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference classification of a measured period: 1, 0, 2 = ignored glitch, 3 = dropout.
   function automatic int cls(input int p);
      if (p < MINP) return 2;
      if (p < THR)  return 1;
      if (p < TMO)  return 0;
      return 3;
   endfunction

   // mode 0: nominal, 1: random in range, 2: range boundaries
   function automatic int pick(input logic b, input int mode);
      int lo, hi;
      lo = b ? MINP : THR;
      hi = b ? THR - 1 : TMO - 1;
      if (mode == 0) return b ? T1 : T0;
      if (mode == 2) return ($urandom_range(0, 1) == 0) ? lo : hi;
      return int'($urandom_range(hi, lo));
   endfunction

   task automatic model_clear();
      m_synced = 1'b0;
      m_cnt = 0;
   endtask

   // Sync-gate reference: returns whether a well-framed byte reaches the consumer.
   task automatic model_byte(input logic [7:0] d, input logic pe, output bit dlv);
      dlv = 1'b1;
      if (SYNC_EN && !m_synced) begin
         dlv = 1'b0;
         if (!pe && d == 8'h16) m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
         else if (!pe && d == 8'h24 && m_cnt == 3) begin m_synced = 1'b1; m_cnt = 0; end
         else m_cnt = 0;
      end
   endtask

   // Next rising edge exactly p cycles after the previous one, optionally with a short
   // low pulse whose rising edge lands at MINP-1 (must be ignored).
   task automatic period(input int p, input bit glitch);
      if (glitch) begin
         while (cyc < last_rise + MINP - 5) @(negedge clk);
         tape_in = 1'b0;
         while (cyc < last_rise + MINP - 1) @(negedge clk);
         tape_in = 1'b1;
      end
      while (cyc < last_rise + p / 2) @(negedge clk);
      tape_in = 1'b0;
      while (cyc < last_rise + p) @(negedge clk);
      tape_in = 1'b1;
      last_rise = cyc;
   endtask

   task automatic arm();
      tape_in = 1'b0;
      repeat (4) @(negedge clk);
      tape_in = 1'b1;
      last_rise = cyc;
   endtask

   task automatic check_out(input int nb, input int nf, input int lat,
                            input logic [7:0] d, input logic pe);
      ev_t e;
      int  fc;
      while (cyc < last_rise + lat + 2) @(negedge clk);
      chk("n_byte_valid", bq.size(), nb);
      chk("n_frame_err", fq.size(), nf);
      if (nb == 1 && bq.size() == 1) begin
         e = bq.pop_front();
         chk("byte_data", e.d, d);
         chk("parity_err", e.pe, pe);
         chk("byte_latency", e.c - last_rise, lat);
      end
      if (nf == 1 && fq.size() == 1) begin
         fc = fq.pop_front();
         chk("frame_err_latency", fc - last_rise, lat);
      end
      chk("byte_data_hold", byte_data, exp_last);
      chk("synced", synced, m_synced);
      bq.delete();
      fq.delete();
   endtask

   task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop0,
                             input int mode, input bit glitch);
      int         per[11];
      logic       b;
      logic [7:0] md;
      logic       pe;
      bit         dlv;
      for (int i = 0; i < 11; i++) begin
         if (i == 0)      b = 1'b0;
         else if (i <= 8) b = d[i-1];
         else if (i == 9) b = (~^d) ^ par_flip;
         else             b = !stop0;
         per[i] = pick(b, mode);
         period(per[i], glitch);
      end
      // Decode purely from the periods that were put on the wire.
      for (int i = 0; i < 8; i++) md[i] = (cls(per[i+1]) == 1);
      pe = ((cls(per[9]) == 1) != ~^md);
      if (cls(per[10]) == 1) begin
         model_byte(md, pe, dlv);
         if (dlv) exp_last = md;
         check_out(dlv ? 1 : 0, 0, 4, md, dlv ? pe : 1'b0);
      end else begin
         model_clear();
         check_out(0, 1, 4, 8'h00, 1'b0);
      end
   endtask

   task automatic partial_frame(input int nbits);
      period(T0, 1'b0);
      for (int i = 0; i < nbits; i++) period(($urandom_range(0, 1) == 0) ? T1 : T0, 1'b0);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_byte_data"}, byte_data, 8'h00);
      chk({tag, "_byte_valid"}, byte_valid, 1'b0);
      chk({tag, "_parity_err"}, parity_err, 1'b0);
      chk({tag, "_frame_err"}, frame_err, 1'b0);
      chk({tag, "_synced"}, synced, 1'b0);
      chk({tag, "_no_err_pulse"}, fq.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded its cycle budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] sync_seq[13];
      sync_seq = '{8'h16, 8'h16, 8'h16, 8'h24, 8'h5A, 8'h16, 8'h16, 8'h24, 8'h33,
                   8'h16, 8'h16, 8'h16, 8'h24};

      // Reset state
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      reset = 1'b0;
      arm();

      // Nominal byte 45h, correct then flipped parity
      send_frame(8'h45, 1'b0, 1'b0, 0, 1'b0);
      send_frame(8'h45, 1'b1, 1'b0, 0, 1'b0);
      // Bad stop bit, then a frame that must start from a fresh hunt
      send_frame(8'h3C, 1'b0, 1'b1, 0, 1'b0);
      send_frame(8'h81, 1'b0, 1'b0, 0, 1'b0);
      // Classification boundaries and glitch rejection
      send_frame(8'($urandom), 1'b0, 1'b0, 2, 1'b0);
      send_frame(8'($urandom), 1'b1, 1'b0, 2, 1'b0);
      send_frame(8'h5A, 1'b0, 1'b0, 0, 1'b1);

      // Dropout after the 4th data bit
      partial_frame(4);
      model_clear();
      check_out(0, 1, TMO + 4, 8'h00, 1'b0);
      arm();
      send_frame(8'hA5, 1'b0, 1'b0, 0, 1'b0);
      // Dropout while hunting is silent
      model_clear();
      check_out(0, 0, TMO + 20, 8'h00, 1'b0);
      arm();

      // Reset mid-DATA
      partial_frame(3);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_idle_outputs("rst_mid");
      reset = 1'b0;
      exp_last = 8'h00;
      model_clear();
      bq.delete(); fq.delete();
      arm();
      send_frame(8'hA5, 1'b0, 1'b0, 0, 1'b0);

      // Motor off mid-DATA
      partial_frame(5);
      @(negedge clk);
      motor = 1'b0;
      @(negedge clk);
      check_idle_outputs("motor_off");
      repeat (3) @(negedge clk);
      motor = 1'b1;
      exp_last = 8'h00;
      model_clear();
      bq.delete(); fq.delete();
      arm();
      send_frame(8'hA5, 1'b0, 1'b0, 0, 1'b0);

      // Sync leader sequence with an aborted frame in the middle
      for (int i = 0; i < 13; i++) begin
         if (i == 5) send_frame(8'h16, 1'b0, 1'b1, 0, 1'b0);
         send_frame(sync_seq[i], 1'b0, 1'b0, 0, 1'b0);
      end
      send_frame(8'h33, 1'b0, 1'b0, 0, 1'b0);

      // Randomized frames with leader filler
      for (int k = 0; k < 14; k++) begin
         int nl;
         nl = int'($urandom_range(2, 0));
         for (int j = 0; j < nl; j++) period(T1, 1'b0);
         send_frame(8'($urandom), ($urandom_range(3, 0) == 0), ($urandom_range(6, 0) == 0),
                    int'($urandom_range(2, 0)), 1'b0);
      end

      chk("stray_parity_err", stray_pe, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
